// File: rtl/burst_spram_pkg.sv
// Shared types and helpers for burst_spram: FSM state encoding and the even-parity function.
package burst_spram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PAR_MAX_W = 64;

  // Even parity: the returned bit makes the total count of ones (data + bit) even.
  function automatic logic parity_f(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/burst_spram_core.sv
// spram_core: word array with one synchronous write/read port; read data registered (1 cycle).
// With BURST_SPRAM_PARITY_EN each word carries an even-parity bit and perr_o flags a mismatch.
module spram_core
  import burst_spram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdat_i,
  output logic [DATA_WIDTH-1:0] rdat_o,
  output logic                  perr_o
);

`ifdef BURST_SPRAM_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  logic [MW-1:0] mem_q [RAM_DEPTH];
  logic [MW-1:0] word_q;
  logic [MW-1:0] wword;

`ifdef BURST_SPRAM_PARITY_EN
  assign wword  = {parity_f(PAR_MAX_W'(wdat_i)), wdat_i};
  assign perr_o = ^word_q;
`else
  assign wword  = wdat_i;
  assign perr_o = 1'b0;
`endif

  assign rdat_o = word_q[DATA_WIDTH-1:0];

  // Contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wword;
    if (re_i) word_q <= mem_q[addr_i];
  end

endmodule

// File: rtl/burst_spram.sv
// Single-port RAM with single accesses and valid/ready burst reads; read latency 1 cycle.
// Output word held until rd_valid&&rd_ready; optional parity via BURST_SPRAM_PARITY_EN.
module burst_spram
  import burst_spram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  burst_start,
  input  logic [ADDR_WIDTH-1:0] burst_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  burst_busy,
  output logic                  burst_done,
  output logic                  parity_err
);

  state_t                state_q, state_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;

  logic                  mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdat;
  logic                  mem_perr;
  logic                  hs, can_load;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  assign hs       = rd_valid_q & rd_ready;
  assign can_load = ~rd_valid_q | rd_ready;

  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q & ~hs;
    done_d     = 1'b0;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = address;
    unique case (state_q)
      IDLE: begin
        if (burst_start) begin
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else if (can_load) begin
            // A pending unconsumed single-read word must not be overwritten.
            mem_re     = 1'b1;
            mem_addr   = burst_addr;
            rd_valid_d = 1'b1;
            addr_d     = next_addr(burst_addr);
            cnt_d      = LEN_WIDTH'(1);
            len_d      = burst_len;
            state_d    = (burst_len == LEN_WIDTH'(1)) ? DRAIN : BURST;
          end
        end else if (cs && we) begin
          mem_we = 1'b1;
        end else if (cs && oe && can_load) begin
          mem_re     = 1'b1;
          rd_valid_d = 1'b1;
        end
      end
      BURST: begin
        if (hs) begin
          mem_re     = 1'b1;
          mem_addr   = addr_q;
          rd_valid_d = 1'b1;
          addr_d     = next_addr(addr_q);
          cnt_d      = cnt_q + LEN_WIDTH'(1);
          if (cnt_q + LEN_WIDTH'(1) == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
    end
  end

  spram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_core (
    .clk_i (clk),
    .we_i  (mem_we),
    .re_i  (mem_re),
    .addr_i(mem_addr),
    .wdat_i(data_in),
    .rdat_o(mem_rdat),
    .perr_o(mem_perr)
  );

  assign rd_valid   = rd_valid_q;
  assign data_out   = rd_valid_q ? mem_rdat : '0;
  assign burst_busy = (state_q != IDLE);
  assign burst_done = done_q;
  assign parity_err = rd_valid_q & mem_perr;

endmodule
